// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared constants for the RV32I hazard controller: opcodes, NOP, stage indices, FSM states.
// No logic; imported by the controller and its decode helper.
// Stage indices follow pipeline order IF=0 .. WB=4.
package hazard_ctrl_unit_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LU_WAIT = 2'd1,
    ST_MD_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_src_decode.sv
// Register-source decode of one RV32I instruction: which source fields are read, plus rd/rs1/rs2.
// Purely combinational, zero latency.
// No flow control.
module hazard_src_decode
  import hazard_ctrl_unit_pkg::*;
(
  input  logic [31:0] instr,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  logic [6:0] opcode;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign rd          = instr[11:7];
  assign rs1         = instr[19:15];
  assign rs2         = instr[24:20];
  assign unused_bits = ^{instr[31:25], instr[14:12]};

  // Only R/S/B formats read rs2; every format except U-type and JAL reads rs1.
  always_comb begin
    uses_rs2 = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
    uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, mul/div hold, branch flush, stall counter.
// hold/bubble/flush/lu_event are Mealy (same cycle as inputs); state and stall_cnt update on clk.
// Never back-pressured itself; MEM and WB are never held or flushed.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int NSTG       = 5,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      ex_instr,
  input  logic             ex_valid,
  input  logic             br_taken,
  input  logic             md_busy,
  output logic [NSTG-1:0]  hold,
  output logic [NSTG-1:0]  bubble,
  output logic [NSTG-1:0]  flush,
  output logic             lu_event,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t     state, state_nxt;
  logic [1:0] lu_cnt, lu_cnt_nxt;

  logic       id_uses_rs1, id_uses_rs2;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       ex_uses_rs1, ex_uses_rs2;
  logic [4:0] ex_rd, ex_rs1, ex_rs2;
  logic       dec_unused;
  logic       lu_hit;

  hazard_src_decode u_dec_id (
    .instr    (id_instr),
    .uses_rs1 (id_uses_rs1),
    .uses_rs2 (id_uses_rs2),
    .rd       (id_rd),
    .rs1      (id_rs1),
    .rs2      (id_rs2)
  );

  hazard_src_decode u_dec_ex (
    .instr    (ex_instr),
    .uses_rs1 (ex_uses_rs1),
    .uses_rs2 (ex_uses_rs2),
    .rd       (ex_rd),
    .rs1      (ex_rs1),
    .rs2      (ex_rs2)
  );

  // Only rd is needed from EX, and only the sources from ID.
  assign dec_unused = ^{id_rd, ex_uses_rs1, ex_uses_rs2, ex_rs1, ex_rs2};

  // A real load in EX whose non-zero destination is read by the instruction in ID.
  always_comb begin
    lu_hit = ex_valid && (ex_instr[6:0] == OP_LOAD) && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && (ex_rd == id_rs1)) || (id_uses_rs2 && (ex_rd == id_rs2)));
  end

  // Per-cycle stage controls and next state; branch flush outranks mul/div, which outranks load-use.
  always_comb begin
    hold       = '0;
    bubble     = '0;
    flush      = '0;
    lu_event   = 1'b0;
    state_nxt  = state;
    lu_cnt_nxt = lu_cnt;
    if (rst) begin
      if (br_taken) begin
        // Squashed ID owes no bubbles; a still-busy mul/div resumes holding next cycle.
        flush[STG_IF] = 1'b1;
        flush[STG_ID] = 1'b1;
        lu_cnt_nxt    = '0;
        state_nxt     = md_busy ? ST_MD_WAIT : ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (md_busy) begin
              hold[STG_IF]    = 1'b1;
              hold[STG_ID]    = 1'b1;
              hold[STG_EX]    = 1'b1;
              bubble[STG_MEM] = 1'b1;
              state_nxt       = ST_MD_WAIT;
            end else if (lu_hit) begin
              hold[STG_IF]   = 1'b1;
              hold[STG_ID]   = 1'b1;
              bubble[STG_EX] = 1'b1;
              lu_event       = 1'b1;
              if (LU_BUBBLES > 1) begin
                lu_cnt_nxt = 2'(LU_BUBBLES - 1);
                state_nxt  = ST_LU_WAIT;
              end
            end
          end
          ST_LU_WAIT: begin
            if (md_busy) begin
              hold[STG_IF]    = 1'b1;
              hold[STG_ID]    = 1'b1;
              hold[STG_EX]    = 1'b1;
              bubble[STG_MEM] = 1'b1;
              lu_cnt_nxt      = '0;
              state_nxt       = ST_MD_WAIT;
            end else begin
              hold[STG_IF]   = 1'b1;
              hold[STG_ID]   = 1'b1;
              bubble[STG_EX] = 1'b1;
              lu_cnt_nxt     = lu_cnt - 2'd1;
              if (lu_cnt == 2'd1) state_nxt = ST_IDLE;
            end
          end
          ST_MD_WAIT: begin
            if (md_busy) begin
              hold[STG_IF]    = 1'b1;
              hold[STG_ID]    = 1'b1;
              hold[STG_EX]    = 1'b1;
              bubble[STG_MEM] = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // State, bubble countdown and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      lu_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
      if ((|hold) && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
